spi_mmio_bridge: RTL and testbench
==================================

SPI_MMIO_BRIDGE -- requirements
Module: spi_mmio_bridge

Interface
REQ-001 Parameters: none; SPI mode 0 (CPOL=0, CPHA=0), MSB first, fixed; clk SHALL be >= 8x sclk.
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 spi_sclk  in  1  SPI clock, asynchronous to clk.
REQ-005 spi_cs_n  in  1  SPI chip select, active-low, asynchronous.
REQ-006 spi_mosi  in  1  SPI serial data from master.
REQ-007 spi_miso  out  1  SPI serial data to master.
REQ-008 spi_miso_oe  out  1  MISO drive enable (1 while cs_n synchronized low).
REQ-009 cs  out  1  MMIO select strobe.
REQ-010 rd  out  1  MMIO read strobe.
REQ-011 wr  out  1  MMIO write strobe.
REQ-012 addr  out  8  MMIO address.
REQ-013 wdata  out  8  MMIO write data.
REQ-014 rdata  in  8  MMIO read data, combinationally valid while cs&rd.
REQ-015 frame_err  out  1  one-cycle pulse on aborted frame.

Function
REQ-016 sclk, cs_n, mosi SHALL pass a 2-flop synchronizer; sclk rise/fall detected from the synchronized value and its delayed copy.
REQ-017 mosi SHALL be sampled on detected sclk rise; received bits shift in MSB first.
REQ-018 Frame = 3 bytes: CMD (bit7=1 write, 0 read; bits6:0 ignored), ADDR, DATA.
REQ-019 FSM states: IDLE, CMD, ADDR, DATA, DONE; 3-bit bit counter within each byte.
REQ-020 IDLE->CMD on synchronized cs_n fall; CMD->ADDR after 8th rise; ADDR->DATA after 16th rise; DATA->DONE after 24th rise.
REQ-021 Any state->IDLE on synchronized cs_n rise, regardless of other events in that cycle.
REQ-022 Read: on the cycle after the 16th rise, cs=rd=1 for exactly one clk with addr=received ADDR; rdata captured into tx shift register in that same cycle.
REQ-023 Write: on the cycle after the 24th rise, cs=wr=1 for exactly one clk with addr and wdata=received DATA.
REQ-024 cs, rd, wr SHALL never be asserted simultaneously with each other except cs with exactly one of rd/wr; max one bus access per frame.
REQ-025 spi_miso = tx[7] in DATA state of a read frame, else 0; tx shifts left on each detected sclk fall in DATA state except the fall preceding the first DATA rise.
REQ-026 Bits received in DONE (>24 per frame) SHALL be ignored; no second access, no error.
REQ-027 cs_n rise before the 24th rise (write) or before the 16th rise (read, or command unknown) SHALL pulse frame_err one clk and perform no write.
REQ-028 cs_n rise in a read frame after the read strobe but before 24 bits SHALL NOT flag frame_err.
REQ-029 addr and wdata hold their last value between accesses.

Reset
REQ-030 On rst_n low: FSM=IDLE, counters=0, shift registers=0, cs=rd=wr=0, frame_err=0, spi_miso=0, spi_miso_oe=0, addr=wdata=0.
REQ-031 Synchronizer flops reset to sclk=0, cs_n=1, mosi=0 so that no edge or frame start is detected on release.
REQ-032 Reset mid-frame SHALL discard the frame; the next frame starts only on a fresh cs_n fall.

Structure
REQ-033 Shared package fuzzy_pkg SHALL hold the FSM state enum, FRAME_BITS=24, CMD_WR_BIT=7.
REQ-034 One sub-module sync_2ff (1-bit, parameterized reset value) SHALL be instantiated for sclk, cs_n, mosi.
REQ-035 Bus outputs SHALL be registered; spi_miso SHALL be driven from a flop.

Verification
REQ-036 Write frame 0x80,0x02,0x5A -> single cs&wr cycle, addr=0x02, wdata=0x5A, one clk after 24th rise synchronized; frame_err=0.
REQ-037 Read frame 0x00,0x30,0x00 with rdata=0x64 -> single cs&rd cycle with addr=0x30; master samples 0x64 on MISO.
REQ-038 Write frame aborted after 20 bits -> no wr, frame_err one-cycle pulse; following full frame executes normally.
REQ-039 32-bit write frame 0x80,0x41,0x03,0xFF -> exactly one write addr=0x41, wdata=0x03; no frame_err.
REQ-040 rst_n pulsed after 10 bits -> all outputs at reset values, no access; next frame 0x80,0x40,0x20 writes addr=0x40, wdata=0x20.
REQ-041 Back-to-back frames with cs_n high for 2 sclk periods at clk=8x sclk -> both accesses performed in order.

Source files
------------

// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the SPI-to-MMIO bridge.
package fuzzy_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StDone
  } state_e;

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned CMD_WR_BIT = 7;
  localparam int unsigned BYTE_BITS  = FRAME_BITS / 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with configurable reset value.
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_mmio_bridge.sv
// SPI mode-0 slave that turns a CMD/ADDR/DATA frame into a single registered MMIO
// read or write strobe; read data is shifted back out on MISO during the DATA byte.
module spi_mmio_bridge
  import fuzzy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(BYTE_BITS);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_q, cs_n_q;

  sync_2ff #(.ResetVal(1'b0)) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (spi_sclk),
    .q_o  (sclk_s)
  );

  sync_2ff #(.ResetVal(1'b1)) u_sync_cs_n (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (spi_cs_n),
    .q_o  (cs_n_s)
  );

  sync_2ff #(.ResetVal(1'b0)) u_sync_mosi (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (spi_mosi),
    .q_o  (mosi_s)
  );

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_n_s & cs_n_q;
  assign cs_rise   = cs_n_s & ~cs_n_q;

  // Frames may only start once cs_n has been seen high with a flushed synchronizer,
  // so a reset released while cs_n is held low cannot start a frame mid-stream.
  logic [1:0] settle_q;
  logic       armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      cs_n_q <= cs_n_s;
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd2 && cs_n_s) armed_q <= 1'b1;
    end
  end

  state_e                 state_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic [BYTE_BITS-1:0]   rx_q, tx_q, addr_rx_q, addr_q, wdata_q;
  logic                   is_wr_q, cs_q, rd_q, wr_q, err_q, miso_q;
  logic [BYTE_BITS-1:0]   rx_byte;
  logic                   last_bit;

  assign rx_byte  = {rx_q[BYTE_BITS-2:0], mosi_s};
  assign last_bit = (bit_cnt_q == CntW'(BYTE_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_rx_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_wr_q   <= 1'b0;
      cs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      cs_q  <= 1'b0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      err_q <= 1'b0;

      // rdata is valid while the read strobe is out; load it for the DATA byte.
      if (cs_q && rd_q) begin
        tx_q   <= rdata;
        miso_q <= rdata[BYTE_BITS-1];
      end

      if (cs_rise) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        miso_q    <= 1'b0;
        err_q     <= (state_q == StCmd) || (state_q == StAddr) ||
                     (state_q == StData && is_wr_q);
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall && armed_q) begin
              state_q   <= StCmd;
              bit_cnt_q <= '0;
              rx_q      <= '0;
            end
          end
          StCmd, StAddr, StData: begin
            if (sclk_rise) begin
              rx_q      <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (last_bit) begin
                if (state_q == StCmd) begin
                  is_wr_q <= rx_byte[CMD_WR_BIT];
                  state_q <= StAddr;
                end else if (state_q == StAddr) begin
                  addr_rx_q <= rx_byte;
                  state_q   <= StData;
                  if (!is_wr_q) begin
                    cs_q   <= 1'b1;
                    rd_q   <= 1'b1;
                    addr_q <= rx_byte;
                  end
                end else begin
                  state_q <= StDone;
                  miso_q  <= 1'b0;
                  if (is_wr_q) begin
                    cs_q    <= 1'b1;
                    wr_q    <= 1'b1;
                    addr_q  <= addr_rx_q;
                    wdata_q <= rx_byte;
                  end
                end
              end
            end else if (sclk_fall && state_q == StData && !is_wr_q && bit_cnt_q != '0) begin
              // The fall before the first DATA rise (bit_cnt 0) keeps bit 7 on the wire.
              tx_q   <= {tx_q[BYTE_BITS-2:0], 1'b0};
              miso_q <= tx_q[BYTE_BITS-2];
            end
          end
          StDone: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~cs_n_s;
  assign cs          = cs_q;
  assign rd          = rd_q;
  assign wr          = wr_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_spi_mmio_bridge.sv
// Scoreboard bench: SPI master stimulus pushes expected bus events, a monitor pops and compares.
`timescale 1ns/1ps
module tb_spi_mmio_bridge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, cs, rd, wr, frame_err;
  logic [7:0] addr, wdata, rdata;
  logic [7:0] rd_val = 8'h00;

  assign rdata = (cs && rd) ? rd_val : 8'h00;

  always #5 clk = ~clk;

  spi_mmio_bridge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .cs         (cs),
    .rd         (rd),
    .wr         (wr),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .frame_err  (frame_err)
  );

  typedef enum logic [1:0] {EvWrite, EvRead, EvErr} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  time t_rise = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{kind: EvWrite, addr: a, data: d});
  endtask

  task automatic expect_rd(input logic [7:0] a);
    exp_q.push_back('{kind: EvRead, addr: a, data: 8'h00});
  endtask

  task automatic expect_err();
    exp_q.push_back('{kind: EvErr, addr: 8'h00, data: 8'h00});
  endtask

  // Mode-0 master: 8 clk per sclk period, MOSI changes while sclk is low, MISO sampled on rise.
  task automatic spi_xfer(input logic [31:0] data, input int nbits, input bit end_frame,
                          output logic [31:0] miso_bits);
    miso_bits = '0;
    @(posedge clk);
    #2;
    spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = data[31-i];
      #40 spi_sclk = 1'b1;
      t_rise    = $time;
      miso_bits = {miso_bits[30:0], spi_miso};
      #40 spi_sclk = 1'b0;
    end
    if (end_frame) begin
      #40 spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      #160;
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    int  lat;
    if (rst_n && (cs || rd || wr || frame_err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {28'd0, cs, rd, wr, frame_err}, 32'd0);
      end else begin
        e   = exp_q.pop_front();
        lat = int'($time - t_rise);
        case (e.kind)
          EvWrite: begin
            chk("write_strobes", {28'd0, cs, rd, wr, frame_err}, 32'b1010);
            chk("write_addr", {24'd0, addr}, {24'd0, e.addr});
            chk("write_data", {24'd0, wdata}, {24'd0, e.data});
            chk("write_latency_ok", {31'd0, (lat >= 20 && lat <= 50)}, 32'd1);
          end
          EvRead: begin
            chk("read_strobes", {28'd0, cs, rd, wr, frame_err}, 32'b1100);
            chk("read_addr", {24'd0, addr}, {24'd0, e.addr});
            chk("read_latency_ok", {31'd0, (lat >= 20 && lat <= 50)}, 32'd1);
          end
          default: begin
            chk("frame_err_pulse", {28'd0, cs, rd, wr, frame_err}, 32'b0001);
          end
        endcase
      end
    end
  end

  initial begin
    logic [31:0] mb;
    #23;
    chk("reset_outputs",
        {10'd0, spi_miso, spi_miso_oe, cs, rd, wr, frame_err, addr, wdata}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Plain write
    expect_wr(8'h02, 8'h5A);
    spi_xfer(32'h80025A00, 24, 1'b1, mb);

    // Plain read, MISO returns rdata during DATA byte
    rd_val = 8'h64;
    expect_rd(8'h30);
    spi_xfer(32'h00300000, 24, 1'b1, mb);
    chk("read_miso_byte", {24'd0, mb[7:0]}, 32'h64);
    chk("read_miso_quiet", {16'd0, mb[23:8]}, 32'd0);
    chk("addr_hold", {24'd0, addr}, 32'h30);
    chk("wdata_hold", {24'd0, wdata}, 32'h5A);

    // Write aborted after 20 bits, then a normal write
    expect_err();
    spi_xfer(32'h80AA5500, 20, 1'b1, mb);
    expect_wr(8'h11, 8'h22);
    spi_xfer(32'h80112200, 24, 1'b1, mb);

    // 32-bit write: trailing byte ignored
    expect_wr(8'h41, 8'h03);
    spi_xfer(32'h804103FF, 32, 1'b1, mb);

    // Reset pulsed mid-frame with cs_n held low
    spi_xfer(32'h80778800, 10, 1'b0, mb);
    chk("oe_in_frame", {31'd0, spi_miso_oe}, 32'd1);
    #30 rst_n = 1'b0;
    #20;
    chk("midframe_reset_outputs",
        {10'd0, spi_miso, spi_miso_oe, cs, rd, wr, frame_err, addr, wdata}, 32'd0);
    #20 rst_n = 1'b1;
    #100 spi_cs_n = 1'b1;
    #160;
    chk("oe_idle", {31'd0, spi_miso_oe}, 32'd0);
    expect_wr(8'h40, 8'h20);
    spi_xfer(32'h80402000, 24, 1'b1, mb);

    // Read aborted after the strobe: no error; MISO already carries the top nibble
    rd_val = 8'hC3;
    expect_rd(8'h55);
    spi_xfer(32'h00550000, 20, 1'b1, mb);
    chk("abort_read_miso_nibble", {28'd0, mb[3:0]}, 32'hC);

    // Read aborted before the address completes
    expect_err();
    spi_xfer(32'h00660000, 12, 1'b1, mb);

    // Back-to-back frames, cs_n high for two sclk periods between them
    rd_val = 8'h9E;
    expect_wr(8'h05, 8'hA5);
    expect_rd(8'h06);
    spi_xfer(32'h8005A500, 24, 1'b1, mb);
    spi_xfer(32'h00060000, 24, 1'b1, mb);
    chk("b2b_read_miso", {24'd0, mb[7:0]}, 32'h9E);

    #200;
    chk("pending_events", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
